// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: requester and wrapper-side signals of the CPU
// memory arbiter; master = arbiter, slave = requesters + bus wrapper.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SW = DATA_W / 8;

  logic              im_req_i;
  logic [ADDR_W-1:0] im_addr_i;
  logic [DATA_W-1:0] im_rdata_o;
  logic              im_done_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [SW-1:0]     dm_wstrb_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_done_o;

  logic              bus_req_o;
  logic              bus_we_o;
  logic [SW-1:0]     bus_wstrb_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i;
  logic              bus_done_i;
  logic [DATA_W-1:0] bus_rdata_i;

  modport master (
    input  im_req_i,
    input  im_addr_i,
    output im_rdata_o,
    output im_done_o,
    input  dm_req_i,
    input  dm_we_i,
    input  dm_wstrb_i,
    input  dm_addr_i,
    input  dm_wdata_i,
    output dm_rdata_o,
    output dm_done_o,
    output bus_req_o,
    output bus_we_o,
    output bus_wstrb_o,
    output bus_addr_o,
    output bus_wdata_o,
    input  bus_ack_i,
    input  bus_done_i,
    input  bus_rdata_i
  );

  modport slave (
    output im_req_i,
    output im_addr_i,
    input  im_rdata_o,
    input  im_done_o,
    output dm_req_i,
    output dm_we_i,
    output dm_wstrb_i,
    output dm_addr_i,
    output dm_wdata_i,
    input  dm_rdata_o,
    input  dm_done_o,
    input  bus_req_o,
    input  bus_we_o,
    input  bus_wstrb_o,
    input  bus_addr_o,
    input  bus_wdata_o,
    output bus_ack_i,
    output bus_done_i,
    output bus_rdata_i
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin share of the single CPU memory port
// between instruction fetch (IM) and load/store (DM).
module cpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic ACLK,
  input  logic ARESETn,
  cpu_mem_arbiter_if.master io
);
  localparam int SW = DATA_W / 8;

  localparam int I_IDLE  = 0;
  localparam int I_GRANT = 1;
  localparam int I_WAIT  = 2;
  localparam int I_RESP  = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    GRANT = 4'b0010,
    WAIT  = 4'b0100,
    RESP  = 4'b1000
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IM,
    OWN_DM
  } own_t;

  state_t state, state_nx;
  own_t   owner, owner_nx;

  logic last_dm, last_dm_nx;
  logic pick_im, pick_dm;
  logic grant_im, grant_dm;
  logic capture;

  logic              we_q;
  logic [SW-1:0]     wstrb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] im_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  // On contention the requester not granted last time wins.
  assign pick_im = io.im_req_i
                 & (~io.dm_req_i | last_dm);
  assign pick_dm = io.dm_req_i & ~pick_im;

  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    last_dm_nx = last_dm;
    grant_im   = 1'b0;
    grant_dm   = 1'b0;
    capture    = 1'b0;
    unique case (1'b1)
      state[I_IDLE]: begin
        grant_im = pick_im;
        grant_dm = pick_dm;
        if (pick_im) begin
          state_nx   = GRANT;
          owner_nx   = OWN_IM;
          last_dm_nx = 1'b0;
        end else if (pick_dm) begin
          state_nx   = GRANT;
          owner_nx   = OWN_DM;
          last_dm_nx = 1'b1;
        end
      end
      state[I_GRANT]: begin
        if (io.bus_ack_i) begin
          capture  = io.bus_done_i & ~we_q;
          state_nx = io.bus_done_i ? RESP : WAIT;
        end
      end
      state[I_WAIT]: begin
        if (io.bus_done_i) begin
          capture  = ~we_q;
          state_nx = RESP;
        end
      end
      state[I_RESP]: begin
        state_nx = IDLE;
        owner_nx = OWN_NONE;
      end
      default: begin
        state_nx = IDLE;
        owner_nx = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      last_dm <= 1'b1;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      last_dm <= last_dm_nx;
    end
  end

  // Request fields are frozen at grant so the wrapper sees stable values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      we_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_im) begin
      we_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= io.im_addr_i;
      wdata_q <= '0;
    end else if (grant_dm) begin
      we_q    <= io.dm_we_i;
      wstrb_q <= io.dm_we_i ? io.dm_wstrb_i : '0;
      addr_q  <= io.dm_addr_i;
      wdata_q <= io.dm_wdata_i;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (capture) begin
      if (owner == OWN_IM) begin
        im_rdata_q <= io.bus_rdata_i;
      end
      if (owner == OWN_DM) begin
        dm_rdata_q <= io.bus_rdata_i;
      end
    end
  end

  assign io.bus_req_o   = state[I_GRANT];
  assign io.bus_we_o    = we_q;
  assign io.bus_wstrb_o = wstrb_q;
  assign io.bus_addr_o  = addr_q;
  assign io.bus_wdata_o = wdata_q;

  assign io.im_done_o  = state[I_RESP]
                       & (owner == OWN_IM);
  assign io.dm_done_o  = state[I_RESP]
                       & (owner == OWN_DM);
  assign io.im_rdata_o = im_rdata_q;
  assign io.dm_rdata_o = dm_rdata_q;
endmodule
